// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: read, write, reserve and clear requests,
// plus registered read data, valid flags and sweep status.
interface reg_file_sb_if #(
   parameter int WORD_SIZE = 16,
   parameter int NIB_SIZE  = 4
);
   logic                 get_enable;
   logic [NIB_SIZE-1:0]  num1;
   logic [NIB_SIZE-1:0]  num2;
   logic                 set_enable;
   logic [NIB_SIZE-1:0]  setnum;
   logic [WORD_SIZE-1:0] setval;
   logic                 reserve_enable;
   logic [NIB_SIZE-1:0]  reserve_num;
   logic                 clear_enable;
   logic [WORD_SIZE-1:0] out1;
   logic [WORD_SIZE-1:0] out2;
   logic                 valid1;
   logic                 valid2;
   logic                 busy;

   modport master (
      output get_enable, num1, num2, set_enable, setnum, setval,
             reserve_enable, reserve_num, clear_enable,
      input  out1, out2, valid1, valid2, busy
   );

   modport slave (
      input  get_enable, num1, num2, set_enable, setnum, setval,
             reserve_enable, reserve_num, clear_enable,
      output out1, out2, valid1, valid2, busy
   );
endinterface

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with write forwarding, per-register
// pending (reservation) bits and a one-register-per-cycle clear sweep.
module reg_file_sb #(
   parameter int WORD_SIZE     = 16,
   parameter int NIB_SIZE      = 4,
   parameter int REG_COUNT     = 16,
   parameter bit HARDWIRE_ZERO = 1'b0
) (
   input logic          clk,
   input logic          reset_enable,
   reg_file_sb_if.slave bus
);

   typedef enum logic {IDLE, SWEEP} state_t;

   localparam logic [NIB_SIZE-1:0] LAST_IDX = NIB_SIZE'(REG_COUNT - 1);

   state_t               state_q, state_d;
   logic [NIB_SIZE-1:0]  idx_q, idx_d;
   logic [WORD_SIZE-1:0] data_q [REG_COUNT];
   logic [REG_COUNT-1:0] pending_q;
   logic [WORD_SIZE-1:0] out1_q, out2_q;
   logic                 valid1_q, valid2_q;
   logic                 set_ok, rsv_ok;
   logic [WORD_SIZE-1:0] rd1_val, rd2_val;
   logic                 rd1_vld, rd2_vld;

   function automatic logic in_range(input logic [NIB_SIZE-1:0] num);
      return int'(num) < REG_COUNT;
   endfunction

   function automatic logic is_zero_reg(input logic [NIB_SIZE-1:0] num);
      return HARDWIRE_ZERO && (num == '0);
   endfunction

   // Returns {valid, data} for one read port, forwarding a same-cycle write.
   function automatic logic [WORD_SIZE:0] read_port(input logic [NIB_SIZE-1:0] num);
      logic [WORD_SIZE:0] r;
      if (is_zero_reg(num))
         r = {1'b1, {WORD_SIZE{1'b0}}};
      else if (set_ok && (bus.setnum == num))
         r = {1'b1, bus.setval};
      else if (!in_range(num))
         r = {1'b1, {WORD_SIZE{1'b0}}};
      else
         r = {~pending_q[num], data_q[num]};
      return r;
   endfunction

   always_comb begin
      set_ok = bus.set_enable && in_range(bus.setnum) && !is_zero_reg(bus.setnum);
      rsv_ok = bus.reserve_enable && in_range(bus.reserve_num) && !is_zero_reg(bus.reserve_num);
      {rd1_vld, rd1_val} = read_port(bus.num1);
      {rd2_vld, rd2_val} = read_port(bus.num2);
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (bus.clear_enable) begin
               state_d = SWEEP;
               idx_d   = '0;
            end
         end
         SWEEP: begin
            idx_d = idx_q + NIB_SIZE'(1);
            if (idx_q == LAST_IDX) begin
               state_d = IDLE;
               idx_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (reset_enable) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // NOTE: the register array is reset explicitly, so it maps to flops rather than a RAM macro.
   always_ff @(posedge clk) begin
      if (reset_enable) begin
         for (int i = 0; i < REG_COUNT; i++) data_q[i] <= '0;
         pending_q <= '0;
         out1_q    <= '0;
         out2_q    <= '0;
         valid1_q  <= 1'b0;
         valid2_q  <= 1'b0;
      end else if (state_q == IDLE) begin
         if (set_ok) begin
            data_q[bus.setnum]    <= bus.setval;
            pending_q[bus.setnum] <= 1'b0;
         end
         // Reserve follows the write so a same-register reserve leaves it pending.
         if (rsv_ok) pending_q[bus.reserve_num] <= 1'b1;
         if (bus.get_enable) begin
            out1_q   <= rd1_val;
            out2_q   <= rd2_val;
            valid1_q <= rd1_vld;
            valid2_q <= rd2_vld;
         end
      end else begin
         data_q[idx_q]    <= '0;
         pending_q[idx_q] <= 1'b0;
         if (bus.get_enable) begin
            out1_q   <= '0;
            out2_q   <= '0;
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
         end
      end
   end

   assign bus.out1   = out1_q;
   assign bus.out2   = out2_q;
   assign bus.valid1 = valid1_q;
   assign bus.valid2 = valid2_q;
   assign bus.busy   = (state_q == SWEEP);

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench: two instances (HARDWIRE_ZERO 0 and 1) share stimulus
// and are compared every cycle against an array-based reference model.
module tb_reg_file_sb;
   localparam int W = 16;
   localparam int N = 4;
   localparam int R = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   reg_file_sb_if #(.WORD_SIZE(W), .NIB_SIZE(N)) bus0 ();
   reg_file_sb_if #(.WORD_SIZE(W), .NIB_SIZE(N)) bus1 ();

   reg_file_sb #(.WORD_SIZE(W), .NIB_SIZE(N), .REG_COUNT(R), .HARDWIRE_ZERO(1'b0))
      dut0 (.clk(clk), .reset_enable(rst), .bus(bus0.slave));
   reg_file_sb #(.WORD_SIZE(W), .NIB_SIZE(N), .REG_COUNT(R), .HARDWIRE_ZERO(1'b1))
      dut1 (.clk(clk), .reset_enable(rst), .bus(bus1.slave));

   // Stimulus shared by both instances
   logic         get_en, set_en, rsv_en, clr;
   logic [N-1:0] n1, n2, sn, rn;
   logic [W-1:0] sv;

   // Reference model, index 0 = plain file, index 1 = hardwired-zero file
   logic [W-1:0] m_data [2][R];
   bit           m_pend [2][R];
   logic [W-1:0] m_out1 [2];
   logic [W-1:0] m_out2 [2];
   bit           m_v1 [2];
   bit           m_v2 [2];
   bit           m_busy [2];
   int           m_idx [2];

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_read(input int u, input int n, output logic [W-1:0] v, output bit ok);
      bit hz = (u == 1);
      if (hz && n == 0) begin
         v = '0; ok = 1'b1;
      end else if (set_en && int'(sn) == n && !(hz && sn == 0)) begin
         v = sv; ok = 1'b1;
      end else if (n >= R) begin
         v = '0; ok = 1'b1;
      end else begin
         v = m_data[u][n]; ok = !m_pend[u][n];
      end
   endtask

   task automatic model_step();
      logic [W-1:0] v1, v2;
      bit ok1, ok2;
      for (int u = 0; u < 2; u++) begin
         bit hz = (u == 1);
         if (rst) begin
            for (int i = 0; i < R; i++) begin
               m_data[u][i] = '0;
               m_pend[u][i] = 1'b0;
            end
            m_out1[u] = '0; m_out2[u] = '0;
            m_v1[u] = 1'b0; m_v2[u] = 1'b0;
            m_busy[u] = 1'b0; m_idx[u] = 0;
         end else if (!m_busy[u]) begin
            if (get_en) begin
               model_read(u, int'(n1), v1, ok1);
               model_read(u, int'(n2), v2, ok2);
               m_out1[u] = v1; m_v1[u] = ok1;
               m_out2[u] = v2; m_v2[u] = ok2;
            end
            if (set_en && !(hz && sn == 0)) begin
               m_data[u][sn] = sv;
               m_pend[u][sn] = 1'b0;
            end
            if (rsv_en && !(hz && rn == 0)) m_pend[u][rn] = 1'b1;
            if (clr) begin
               m_busy[u] = 1'b1;
               m_idx[u]  = 0;
            end
         end else begin
            if (get_en) begin
               m_out1[u] = '0; m_out2[u] = '0;
               m_v1[u] = 1'b0; m_v2[u] = 1'b0;
            end
            m_data[u][m_idx[u]] = '0;
            m_pend[u][m_idx[u]] = 1'b0;
            m_idx[u]++;
            if (m_idx[u] == R) m_busy[u] = 1'b0;
         end
      end
   endtask

   task automatic apply();
      bus0.get_enable = get_en; bus1.get_enable = get_en;
      bus0.num1 = n1; bus1.num1 = n1;
      bus0.num2 = n2; bus1.num2 = n2;
      bus0.set_enable = set_en; bus1.set_enable = set_en;
      bus0.setnum = sn; bus1.setnum = sn;
      bus0.setval = sv; bus1.setval = sv;
      bus0.reserve_enable = rsv_en; bus1.reserve_enable = rsv_en;
      bus0.reserve_num = rn; bus1.reserve_num = rn;
      bus0.clear_enable = clr; bus1.clear_enable = clr;
   endtask

   task automatic compare_all();
      check("u0.out1", 32'(bus0.out1), 32'(m_out1[0]));
      check("u0.out2", 32'(bus0.out2), 32'(m_out2[0]));
      check("u0.valid1", 32'(bus0.valid1), 32'(m_v1[0]));
      check("u0.valid2", 32'(bus0.valid2), 32'(m_v2[0]));
      check("u0.busy", 32'(bus0.busy), 32'(m_busy[0]));
      check("u1.out1", 32'(bus1.out1), 32'(m_out1[1]));
      check("u1.out2", 32'(bus1.out2), 32'(m_out2[1]));
      check("u1.valid1", 32'(bus1.valid1), 32'(m_v1[1]));
      check("u1.valid2", 32'(bus1.valid2), 32'(m_v2[1]));
      check("u1.busy", 32'(bus1.busy), 32'(m_busy[1]));
   endtask

   // Drive current stimulus across one rising edge, then compare 1 time unit later.
   task automatic tick();
      apply();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle_inputs();
      rst = 1'b0; get_en = 1'b0; set_en = 1'b0; rsv_en = 1'b0; clr = 1'b0;
      n1 = '0; n2 = '0; sn = '0; rn = '0; sv = '0;
   endtask

   initial begin
      int cnt;
      idle_inputs();
      rst = 1'b1;
      tick();
      check("reset.out1", 32'(bus0.out1), 32'h0);
      check("reset.busy", 32'(bus0.busy), 32'h0);
      rst = 1'b0;

      // Write then read back; unwritten register reads 0
      set_en = 1'b1; sn = 4'd3; sv = 16'h1234;
      tick();
      idle_inputs(); get_en = 1'b1; n1 = 4'd3; n2 = 4'd5;
      tick();
      check("rd.r3", 32'(bus0.out1), 32'h1234);
      check("rd.r3.valid", 32'(bus0.valid1), 32'h1);
      check("rd.r5", 32'(bus0.out2), 32'h0);
      check("rd.r5.valid", 32'(bus0.valid2), 32'h1);

      // Same-edge write forwarding to both ports
      idle_inputs(); set_en = 1'b1; sn = 4'd7; sv = 16'hBEEF;
      get_en = 1'b1; n1 = 4'd7; n2 = 4'd7;
      tick();
      check("fwd.out1", 32'(bus0.out1), 32'hBEEF);
      check("fwd.out2", 32'(bus0.out2), 32'hBEEF);
      check("fwd.valid2", 32'(bus0.valid2), 32'h1);

      // Reserve, hazard, write clears pending with forwarding
      idle_inputs(); rsv_en = 1'b1; rn = 4'd4;
      tick();
      idle_inputs(); get_en = 1'b1; n1 = 4'd4;
      tick();
      check("rsv.valid1", 32'(bus0.valid1), 32'h0);
      set_en = 1'b1; sn = 4'd4; sv = 16'h0055;
      tick();
      check("rsv.fwd.out1", 32'(bus0.out1), 32'h55);
      check("rsv.fwd.valid1", 32'(bus0.valid1), 32'h1);
      set_en = 1'b0;
      tick();
      check("rsv.after.valid1", 32'(bus0.valid1), 32'h1);

      // Fill, then sweep: busy length, sweep reads, ignored write
      idle_inputs(); set_en = 1'b1;
      for (int i = 0; i < R; i++) begin
         sn = N'(i); sv = W'((i + 1) * 16'h0101);
         tick();
      end
      idle_inputs(); clr = 1'b1;
      tick();
      idle_inputs(); get_en = 1'b1; n1 = 4'd2; n2 = 4'd9;
      set_en = 1'b1; sn = 4'd2; sv = 16'hAAAA;
      cnt = 0;
      while (bus0.busy === 1'b1 && cnt < 40) begin
         check("sweep.valid1", 32'(bus0.valid1), (cnt == 0) ? 32'h1 : 32'h0);
         cnt++;
         tick();
      end
      check("sweep.busy_cycles", 32'(cnt), 32'd16);
      idle_inputs(); get_en = 1'b1;
      for (int i = 0; i < R; i += 2) begin
         n1 = N'(i); n2 = N'(i + 1);
         tick();
         check("swept.out1", 32'(bus0.out1), 32'h0);
         check("swept.out2", 32'(bus0.out2), 32'h0);
      end

      // Register 0 handling with and without hardwired zero
      idle_inputs(); set_en = 1'b1; sn = 4'd0; sv = 16'hFFFF; rsv_en = 1'b1; rn = 4'd0;
      tick();
      idle_inputs(); get_en = 1'b1; n1 = 4'd0;
      tick();
      check("hz.out1", 32'(bus1.out1), 32'h0);
      check("hz.valid1", 32'(bus1.valid1), 32'h1);
      check("nohz.out1", 32'(bus0.out1), 32'hFFFF);
      check("nohz.valid1", 32'(bus0.valid1), 32'h0);

      // Reset in the middle of a sweep
      idle_inputs(); clr = 1'b1;
      tick();
      idle_inputs();
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      tick();
      check("midrst.busy", 32'(bus0.busy), 32'h0);
      idle_inputs(); set_en = 1'b1; sn = 4'd9; sv = 16'h9999;
      tick();
      idle_inputs(); get_en = 1'b1; n1 = 4'd9; n2 = 4'd4;
      tick();
      check("midrst.wr", 32'(bus0.out1), 32'h9999);
      check("midrst.r4", 32'(bus0.out2), 32'h0);

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         rst    = ($urandom_range(0, 299) == 0);
         get_en = ($urandom_range(0, 9) < 7);
         set_en = ($urandom_range(0, 1) == 1);
         rsv_en = ($urandom_range(0, 9) < 3);
         clr    = ($urandom_range(0, 59) == 0);
         sn     = N'($urandom_range(0, R - 1));
         sv     = W'($urandom);
         n1     = ($urandom_range(0, 3) == 0) ? sn : N'($urandom_range(0, R - 1));
         n2     = ($urandom_range(0, 3) == 0) ? sn : N'($urandom_range(0, R - 1));
         rn     = ($urandom_range(0, 3) == 0) ? sn : N'($urandom_range(0, R - 1));
         if ($urandom_range(0, 7) == 0) begin
            n1 = '0; sn = '0; rn = '0;
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
